write_dest_fsm: RTL and testbench

- Destination-side DMA write engine; sits directly downstream of the source read FSM and the data FIFO it fills.
- Pops {packet_complete, last, data} words from the show-ahead data FIFO and issues AXI-MM write bursts to descriptor.dest_addr.
- Collects B responses and pulses wr_fsm_done, which lets the read FSM ack the descriptor.
- Provides write-side status and performance counters to the CSR block.

---
 rtl/write_dest_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_write_dest_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_dest_fsm.sv
// rtl/write_dest_fsm.sv - DMA destination write engine: data FIFO to AXI-MM write bursts
// IDLE is encoded as all zeros; every other state owns one bit of wr_state.
module write_dest_fsm #(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = 64,
  parameter int LENGTH_W        = 32,
  parameter int AXI_LEN_W       = 3,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PERF_CNTR_W     = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic                   desc_valid,
  input  logic [ADDR_W-1:0]      dest_addr,
  input  logic [LENGTH_W-1:0]    length,
  input  logic                   fifo_empty,
  input  logic [DATA_W+1:0]      fifo_rd_data,
  output logic                   fifo_rd_en,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [AXI_LEN_W-1:0]   awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [DATA_W-1:0]      wdata,
  output logic [DATA_W/8-1:0]    wstrb,
  output logic                   wlast,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   wr_fsm_done,
  output logic                   busy,
  output logic                   wr_rsp_err,
  output logic [4:0]             wr_state,
  output logic [PERF_CNTR_W-1:0] wr_clk_cnt,
  output logic [PERF_CNTR_W-1:0] wr_valid_cnt
);

  localparam int BPB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BPB * (1 << AXI_LEN_W));

  typedef enum logic [4:0] {
    IDLE   = 5'b00000,
    AW_REQ = 5'b00001,
    W_DATA = 5'b00010,
    WAIT_B = 5'b00100,
    DONE   = 5'b01000,
    ERROR  = 5'b10000
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [AXI_LEN_W-1:0]   awlen_q, awlen_d;
  logic [AXI_LEN_W-1:0]   last_len_q, last_len_d;
  logic [AXI_LEN_W-1:0]   beat_q, beat_d;
  logic [LENGTH_W-1:0]    num_bursts_q, num_bursts_d;
  logic [LENGTH_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [LENGTH_W-1:0]    b_cnt_q, b_cnt_d;
  logic [2:0]             out_q, out_d;
  logic                   err_q, err_d;
  logic [PERF_CNTR_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [PERF_CNTR_W-1:0] valid_cnt_q, valid_cnt_d;

  logic [LENGTH_W-1:0] len_m1, nb_calc;
  logic aw_hs, w_hs, b_hs, last_burst, next_is_last, fin_beat, beat_bad;

  assign len_m1  = length - LENGTH_W'(1);
  assign nb_calc = (len_m1 >> AXI_LEN_W) + LENGTH_W'(1);

  assign awvalid    = (state_q == AW_REQ) && (out_q < 3'(MAX_OUTSTANDING));
  assign wvalid     = (state_q == W_DATA) && !fifo_empty;
  assign bready     = (state_q != IDLE);
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  assign fifo_rd_en = w_hs;

  assign last_burst   = (burst_cnt_q == num_bursts_q - LENGTH_W'(1));
  assign next_is_last = (burst_cnt_q + LENGTH_W'(2) == num_bursts_q);
  assign wlast        = (state_q == W_DATA) && (beat_q == awlen_q);
  assign fin_beat     = wlast && last_burst;
  // FIFO framing must line up with our burst boundaries and the transfer end.
  assign beat_bad     = (fifo_rd_data[DATA_W] != wlast) ||
                        (fin_beat && !fifo_rd_data[DATA_W+1]);

  assign awaddr       = awaddr_q;
  assign awlen        = awlen_q;
  assign awsize       = 3'($clog2(BPB));
  assign awburst      = 2'b01;
  assign wdata        = fifo_rd_data[DATA_W-1:0];
  assign wstrb        = '1;
  assign wr_fsm_done  = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign wr_rsp_err   = err_q;
  assign wr_state     = state_q;
  assign wr_clk_cnt   = clk_cnt_q;
  assign wr_valid_cnt = valid_cnt_q;

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    last_len_d   = last_len_q;
    beat_d       = beat_q;
    num_bursts_d = num_bursts_q;
    burst_cnt_d  = burst_cnt_q;
    b_cnt_d      = b_cnt_q;
    out_d        = out_q;
    err_d        = err_q;
    clk_cnt_d    = clk_cnt_q;
    valid_cnt_d  = valid_cnt_q;

    if (state_q != IDLE) clk_cnt_d = clk_cnt_q + PERF_CNTR_W'(1);
    if (w_hs)            valid_cnt_d = valid_cnt_q + PERF_CNTR_W'(1);
    if (b_hs)            b_cnt_d = b_cnt_q + LENGTH_W'(1);
    if (aw_hs && !b_hs)  out_d = out_q + 3'd1;
    if (!aw_hs && b_hs)  out_d = out_q - 3'd1;

    case (state_q)
      IDLE: begin
        if (go && desc_valid) begin
          state_d      = AW_REQ;
          awaddr_d     = dest_addr;
          num_bursts_d = nb_calc;
          last_len_d   = len_m1[AXI_LEN_W-1:0];
          awlen_d      = (nb_calc == LENGTH_W'(1)) ? len_m1[AXI_LEN_W-1:0] : '1;
          beat_d       = '0;
          burst_cnt_d  = '0;
          b_cnt_d      = '0;
          out_d        = '0;
          clk_cnt_d    = '0;
          valid_cnt_d  = '0;
        end
      end
      AW_REQ: begin
        if (aw_hs) begin
          state_d = W_DATA;
          beat_d  = '0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (beat_bad) begin
            state_d = ERROR;
          end else if (wlast) begin
            if (last_burst) begin
              state_d = WAIT_B;
            end else begin
              state_d     = AW_REQ;
              burst_cnt_d = burst_cnt_q + LENGTH_W'(1);
              awaddr_d    = awaddr_q + BURST_BYTES;
              awlen_d     = next_is_last ? last_len_q : '1;
            end
          end else begin
            beat_d = beat_q + AXI_LEN_W'(1);
          end
        end
      end
      WAIT_B: begin
        if ((b_cnt_q == num_bursts_q) && (out_q == 3'd0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERROR:   if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A slave error response overrides whatever the FSM was doing.
    if (b_hs && (bresp != 2'b00)) begin
      err_d   = 1'b1;
      state_d = ERROR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      last_len_q   <= '0;
      beat_q       <= '0;
      num_bursts_q <= '0;
      burst_cnt_q  <= '0;
      b_cnt_q      <= '0;
      out_q        <= '0;
      err_q        <= 1'b0;
      clk_cnt_q    <= '0;
      valid_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      last_len_q   <= last_len_d;
      beat_q       <= beat_d;
      num_bursts_q <= num_bursts_d;
      burst_cnt_q  <= burst_cnt_d;
      b_cnt_q      <= b_cnt_d;
      out_q        <= out_d;
      err_q        <= err_d;
      clk_cnt_q    <= clk_cnt_d;
      valid_cnt_q  <= valid_cnt_d;
    end
  end

endmodule

// File: tb/tb_write_dest_fsm.sv
// tb/tb_write_dest_fsm.sv - directed bench for write_dest_fsm with FIFO and AXI slave models
module tb_write_dest_fsm;
  localparam int DATA_W = 512, ADDR_W = 64, LENGTH_W = 32, AXI_LEN_W = 3;
  localparam int MAX_OUT = 2, PW = 64;
  localparam logic [4:0] ST_IDLE = 5'b00000, ST_ERROR = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, go, desc_valid, fifo_empty, fifo_rd_en;
  logic [ADDR_W-1:0]    dest_addr, awaddr;
  logic [LENGTH_W-1:0]  length;
  logic [DATA_W+1:0]    fifo_rd_data;
  logic                 awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [AXI_LEN_W-1:0] awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst, bresp;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W/8-1:0]  wstrb;
  logic                 wr_fsm_done, busy, wr_rsp_err;
  logic [4:0]           wr_state;
  logic [PW-1:0]        wr_clk_cnt, wr_valid_cnt;

  write_dest_fsm #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W), .AXI_LEN_W(AXI_LEN_W),
    .MAX_OUTSTANDING(MAX_OUT), .PERF_CNTR_W(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .desc_valid(desc_valid),
    .dest_addr(dest_addr), .length(length), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .wr_fsm_done(wr_fsm_done), .busy(busy), .wr_rsp_err(wr_rsp_err),
    .wr_state(wr_state), .wr_clk_cnt(wr_clk_cnt), .wr_valid_cnt(wr_valid_cnt)
  );

  int total = 0;
  int bad = 0;

  logic [DATA_W+1:0]    fq[$];
  logic [ADDR_W-1:0]    aw_addr_l[$];
  logic [AXI_LEN_W-1:0] aw_len_l[$];
  logic [31:0]          w_tag_l[$];
  logic                 w_last_l[$];
  int  done_cnt, beats, aw_cnt, b_cnt, bursts_w, b_pend, viol, err_b, tmo;
  bit  stall, prev_awv, prev_awr;
  logic [ADDR_W-1:0] prev_addr;

  // One clock: drive inputs at negedge, observe what the next posedge will accept.
  task automatic cycle();
    @(negedge clk);
    awready      = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready       = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    fifo_empty   = (fq.size() == 0) || (stall && $urandom_range(0, 4) == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
    bvalid       = (b_pend > 0) && (!stall || $urandom_range(0, 1) == 1);
    bresp        = (bvalid && (b_cnt + 1 == err_b)) ? 2'b10 : 2'b00;
    #1;
    if (fifo_rd_en !== (wvalid & wready)) viol++;
    if (wvalid && fifo_empty) viol++;
    if (prev_awv && !prev_awr && (awvalid !== 1'b1 || awaddr !== prev_addr)) viol++;
    prev_awv  = awvalid;
    prev_awr  = awready;
    prev_addr = awaddr;
    if (wr_fsm_done === 1'b1) begin
      done_cnt++;
      go = 1'b0;
      desc_valid = 1'b0;
    end
    if (awvalid && awready) begin
      aw_addr_l.push_back(awaddr);
      aw_len_l.push_back(awlen);
      aw_cnt++;
      if (aw_cnt - b_cnt > MAX_OUT) viol++;
    end
    if (wvalid && wready) begin
      if (aw_cnt <= bursts_w) viol++;
      if (wdata !== fq[0][DATA_W-1:0]) viol++;
      w_tag_l.push_back(wdata[31:0]);
      w_last_l.push_back(wlast);
      void'(fq.pop_front());
      beats++;
      if (wlast) begin
        bursts_w++;
        b_pend++;
      end
    end
    if (bvalid && bready) begin
      b_cnt++;
      b_pend--;
    end
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] addr, input int len, input bit st,
                          input int eb, input int bad_idx, input int stop_beats);
    logic [31:0] tag;
    int cyc;
    fq.delete(); aw_addr_l.delete(); aw_len_l.delete(); w_tag_l.delete(); w_last_l.delete();
    done_cnt = 0; beats = 0; aw_cnt = 0; b_cnt = 0; bursts_w = 0; b_pend = 0; viol = 0;
    prev_awv = 0; prev_awr = 0; prev_addr = '0; tmo = 0;
    stall = st; err_b = eb;
    for (int i = 0; i < len; i++) begin
      tag = addr[31:0] + 32'(i);
      fq.push_back({(i == len - 1), ((i % 8 == 7) || (i == len - 1) || (i == bad_idx)), {16{tag}}});
    end
    dest_addr = addr; length = LENGTH_W'(len); go = 1'b1; desc_valid = 1'b1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      cycle();
      if (done_cnt > 0 || wr_state === ST_ERROR || (stop_beats > 0 && beats >= stop_beats)) break;
    end
    if (cyc >= 3000) tmo = 1;
    if (done_cnt > 0) repeat (3) cycle();
  endtask

  task automatic test_reset();
    total++; if (wr_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0h want=0", wr_state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({awvalid, wvalid, bready, fifo_rd_en, wr_fsm_done} !== 5'b0) begin bad++; $display("FAIL reset_valids got=%b want=00000", {awvalid, wvalid, bready, fifo_rd_en, wr_fsm_done}); end
    total++; if (wr_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", wr_rsp_err); end
    total++; if (wr_clk_cnt !== '0 || wr_valid_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", wr_clk_cnt, wr_valid_cnt); end
    total++; if (awaddr !== '0 || awlen !== '0) begin bad++; $display("FAIL reset_aw got=%0h/%0d want=0/0", awaddr, awlen); end
    total++; if (awsize !== 3'd6 || awburst !== 2'b01 || wstrb !== {64{1'b1}}) begin bad++; $display("FAIL reset_const got=%0d/%0d want=6/1", awsize, awburst); end
  endtask

  task automatic test_three_bursts();
    logic [ADDR_W-1:0]    exp_addr[3];
    logic [AXI_LEN_W-1:0] exp_len[3];
    exp_addr = '{64'h1000, 64'h1200, 64'h1400};
    exp_len  = '{3'd7, 3'd7, 3'd3};
    run_xfer(64'h1000, 20, 0, 0, -1, 0);
    total++; if (tmo !== 0) begin bad++; $display("FAIL tb3_timeout got=%0d want=0", tmo); end
    total++; if (aw_cnt !== 3) begin bad++; $display("FAIL tb3_aw_count got=%0d want=3", aw_cnt); end
    for (int i = 0; i < 3 && i < aw_cnt; i++) begin
      total++; if (aw_addr_l[i] !== exp_addr[i] || aw_len_l[i] !== exp_len[i]) begin bad++; $display("FAIL tb3_aw%0d got=%0h/%0d want=%0h/%0d", i, aw_addr_l[i], aw_len_l[i], exp_addr[i], exp_len[i]); end
    end
    total++; if (beats !== 20) begin bad++; $display("FAIL tb3_beats got=%0d want=20", beats); end
    for (int i = 0; i < beats; i++) begin
      total++; if (w_last_l[i] !== ((i == 7) || (i == 15) || (i == 19))) begin bad++; $display("FAIL tb3_wlast%0d got=%b", i, w_last_l[i]); end
      total++; if (w_tag_l[i] !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL tb3_data%0d got=%0h want=%0h", i, w_tag_l[i], 32'h1000 + 32'(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL tb3_done got=%0d want=1", done_cnt); end
    total++; if (wr_valid_cnt !== 64'd20) begin bad++; $display("FAIL tb3_valid_cnt got=%0d want=20", wr_valid_cnt); end
    total++; if (wr_clk_cnt !== 64'd26) begin bad++; $display("FAIL tb3_clk_cnt got=%0d want=26", wr_clk_cnt); end
    total++; if (wr_state !== ST_IDLE || busy !== 1'b0 || wr_rsp_err !== 1'b0) begin bad++; $display("FAIL tb3_idle got=%0h/%b/%b want=0/0/0", wr_state, busy, wr_rsp_err); end
    total++; if (viol !== 0) begin bad++; $display("FAIL tb3_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_single_beat();
    run_xfer(64'h2000, 1, 0, 0, -1, 0);
    total++; if (tmo !== 0 || done_cnt !== 1) begin bad++; $display("FAIL one_done got=%0d tmo=%0d want=1", done_cnt, tmo); end
    total++; if (aw_cnt !== 1 || aw_len_l[0] !== 3'd0 || aw_addr_l[0] !== 64'h2000) begin bad++; $display("FAIL one_aw got=%0d want=1 awlen0 @2000", aw_cnt); end
    total++; if (beats !== 1 || w_last_l[0] !== 1'b1) begin bad++; $display("FAIL one_beat got=%0d want=1 with wlast", beats); end
    total++; if (wr_valid_cnt !== 64'd1) begin bad++; $display("FAIL one_valid_cnt got=%0d want=1", wr_valid_cnt); end
    run_xfer(64'h3000, 9, 0, 0, -1, 0);
    total++; if (tmo !== 0 || done_cnt !== 1) begin bad++; $display("FAIL second_done got=%0d tmo=%0d want=1", done_cnt, tmo); end
    total++; if (aw_cnt !== 2 || aw_addr_l[1] !== 64'h3200 || aw_len_l[0] !== 3'd7 || aw_len_l[1] !== 3'd0) begin bad++; $display("FAIL second_aw got=%0d want=2 bursts 7/0", aw_cnt); end
    total++; if (beats !== 9 || w_last_l[7] !== 1'b1 || w_last_l[8] !== 1'b1 || w_last_l[6] !== 1'b0) begin bad++; $display("FAIL second_beats got=%0d want=9", beats); end
  endtask

  task automatic test_stalls();
    int order_err = 0;
    run_xfer(64'h8000, 64, 1, 0, -1, 0);
    total++; if (tmo !== 0 || done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d tmo=%0d want=1", done_cnt, tmo); end
    total++; if (beats !== 64) begin bad++; $display("FAIL stall_beats got=%0d want=64", beats); end
    for (int i = 0; i < beats; i++)
      if (w_tag_l[i] !== 32'h8000 + 32'(i)) order_err++;
    total++; if (order_err !== 0) begin bad++; $display("FAIL stall_order got=%0d bad beats want=0", order_err); end
    total++; if (aw_cnt !== 8) begin bad++; $display("FAIL stall_aw got=%0d want=8", aw_cnt); end
    for (int i = 0; i < 8 && i < aw_cnt; i++) begin
      total++; if (aw_addr_l[i] !== 64'h8000 + 64'(i) * 64'h200 || aw_len_l[i] !== 3'd7) begin bad++; $display("FAIL stall_aw%0d got=%0h/%0d", i, aw_addr_l[i], aw_len_l[i]); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL stall_protocol got=%0d want=0", viol); end
    total++; if (wr_valid_cnt !== 64'd64) begin bad++; $display("FAIL stall_valid_cnt got=%0d want=64", wr_valid_cnt); end
  endtask

  task automatic test_bad_last();
    run_xfer(64'h5000, 16, 0, 0, 4, 0);
    total++; if (tmo !== 0 || wr_state !== ST_ERROR) begin bad++; $display("FAIL badlast_state got=%0h want=10", wr_state); end
    total++; if (beats !== 5) begin bad++; $display("FAIL badlast_beats got=%0d want=5", beats); end
    total++; if (wvalid !== 1'b0 || awvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL badlast_valids got=%b%b%b want=000", wvalid, awvalid, fifo_rd_en); end
    total++; if (done_cnt !== 0 || wr_rsp_err !== 1'b0) begin bad++; $display("FAIL badlast_flags got=%0d/%b want=0/0", done_cnt, wr_rsp_err); end
    go = 1'b0; desc_valid = 1'b0;
    repeat (3) cycle();
    total++; if (wr_state !== ST_IDLE) begin bad++; $display("FAIL badlast_recover got=%0h want=0", wr_state); end
  endtask

  task automatic test_bresp_err();
    run_xfer(64'h7000, 20, 0, 2, -1, 0);
    total++; if (tmo !== 0 || wr_state !== ST_ERROR) begin bad++; $display("FAIL bresp_state got=%0h want=10", wr_state); end
    total++; if (wr_rsp_err !== 1'b1) begin bad++; $display("FAIL bresp_err got=%b want=1", wr_rsp_err); end
    total++; if (b_cnt !== 2) begin bad++; $display("FAIL bresp_bcount got=%0d want=2", b_cnt); end
    repeat (4) cycle();
    total++; if (wr_state !== ST_ERROR || done_cnt !== 0 || wvalid !== 1'b0 || awvalid !== 1'b0) begin bad++; $display("FAIL bresp_hold got=%0h done=%0d want=10 done=0", wr_state, done_cnt); end
    go = 1'b0; desc_valid = 1'b0;
    repeat (3) cycle();
    total++; if (wr_state !== ST_IDLE || busy !== 1'b0) begin bad++; $display("FAIL bresp_idle got=%0h/%b want=0/0", wr_state, busy); end
    total++; if (wr_rsp_err !== 1'b1) begin bad++; $display("FAIL bresp_sticky got=%b want=1", wr_rsp_err); end
  endtask

  task automatic test_reset_mid();
    run_xfer(64'h6000, 20, 0, 0, -1, 3);
    total++; if (tmo !== 0 || wr_state !== 5'b00010) begin bad++; $display("FAIL rstmid_pre got=%0h want=2", wr_state); end
    reset_n = 1'b0;
    #1;
    total++; if (wr_state !== ST_IDLE || busy !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%0h/%b want=0/0", wr_state, busy); end
    total++; if ({awvalid, wvalid, bready, fifo_rd_en, wlast} !== 5'b0) begin bad++; $display("FAIL rstmid_valids got=%b want=00000", {awvalid, wvalid, bready, fifo_rd_en, wlast}); end
    total++; if (wr_rsp_err !== 1'b0 || wr_valid_cnt !== '0 || wr_clk_cnt !== '0 || awaddr !== '0) begin bad++; $display("FAIL rstmid_regs got=%b/%0d/%0d/%0h want=0", wr_rsp_err, wr_valid_cnt, wr_clk_cnt, awaddr); end
    go = 1'b0; desc_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_xfer(64'h4000, 9, 0, 0, -1, 0);
    total++; if (tmo !== 0 || done_cnt !== 1 || wr_valid_cnt !== 64'd9) begin bad++; $display("FAIL rstmid_after got=%0d/%0d want=1/9", done_cnt, wr_valid_cnt); end
    total++; if (aw_cnt !== 2 || aw_addr_l[0] !== 64'h4000 || viol !== 0) begin bad++; $display("FAIL rstmid_aw got=%0d viol=%0d want=2/0", aw_cnt, viol); end
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; desc_valid = 1'b0; dest_addr = '0; length = '0;
    fifo_empty = 1'b1; fifo_rd_data = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; stall = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_three_bursts();
    test_single_beat();
    test_stalls();
    test_bad_last();
    test_bresp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
